mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_if.sv | 33 +++
 rtl/mc_control.sv | 182 ++++++++++++++++++
 tb/tb_mc_control.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Instruction-level control bus for the multicycle controller: decode inputs
// from the datapath and all datapath control strobes back out.
interface mc_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero_flag;
  logic [2:0] ALU_control;
  logic       IorD;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       PCEn;
  logic       instr_done;
  logic       illegal_op;
  logic [1:0] ALUSrcB;
  logic [1:0] PCSrc;
  logic [3:0] state;

  modport master (
    output op, funct, zero_flag,
    input  ALU_control, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, PCEn, instr_done, illegal_op, ALUSrcB, PCSrc, state
  );

  modport slave (
    input  op, funct, zero_flag,
    output ALU_control, IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, PCEn, instr_done, illegal_op, ALUSrcB, PCSrc, state
  );
endinterface

// File: rtl/mc_control.sv
// Moore FSM controller for a multicycle MIPS-style datapath (lw/sw/R-type/
// beq/addi/j). Outputs decode from state; write strobes are masked in reset.
module mc_control #(
  parameter bit MUL_EN = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  mc_control_if.slave bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Returns {unmapped, alu_control} for an R-type funct field.
  function automatic logic [3:0] funct_decode(input logic [5:0] f);
    case (f)
      6'b100000: funct_decode = 4'b0010;
      6'b100010: funct_decode = 4'b0100;
      6'b100100: funct_decode = 4'b0000;
      6'b100101: funct_decode = 4'b0001;
      6'b101010: funct_decode = 4'b0110;
      6'b011000: funct_decode = MUL_EN ? 4'b0101 : 4'b1000;
      default:   funct_decode = 4'b1000;
    endcase
  endfunction

  state_t     r_state;
  logic       r_funct_bad;
  state_t     w_next;
  logic [3:0] w_fdec;
  logic [2:0] w_alu_ctl;
  logic [1:0] w_srcb;
  logic [1:0] w_pcsrc;
  logic       w_iord, w_irwrite, w_memwrite, w_regdst, w_memtoreg, w_regwrite;
  logic       w_srca, w_pcwrite, w_branch, w_done, w_illegal;

  assign w_fdec = funct_decode(bus.funct);

  // State register; the funct legality flag is captured in EXECUTE for ALUWB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_funct_bad <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXECUTE) begin
        r_funct_bad <= w_fdec[3];
      end else begin
        r_funct_bad <= r_funct_bad;
      end
    end
  end

  // Next-state and per-state control decode.
  always_comb begin
    w_next     = S_FETCH;
    w_alu_ctl  = 3'b010;
    w_srcb     = 2'b00;
    w_pcsrc    = 2'b00;
    w_iord     = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_srca     = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_done     = 1'b0;
    w_illegal  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_srcb    = 2'b01;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        w_srcb = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYP:      w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_next = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_MEMWR: begin
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_EXECUTE: begin
        w_srca    = 1'b1;
        w_alu_ctl = w_fdec[2:0];
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = ~r_funct_bad;
        w_illegal  = r_funct_bad;
        w_done     = 1'b1;
      end
      S_BRANCH: begin
        w_srca    = 1'b1;
        w_alu_ctl = 3'b100;
        w_pcsrc   = 2'b01;
        w_branch  = 1'b1;
        w_done    = 1'b1;
      end
      S_ADDIEX: begin
        w_srca = 1'b1;
        w_srcb = 2'b10;
        w_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
        w_done     = 1'b1;
      end
      S_JUMP: begin
        w_pcsrc   = 2'b10;
        w_pcwrite = 1'b1;
        w_done    = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign bus.state       = r_state;
  assign bus.ALU_control = w_alu_ctl;
  assign bus.ALUSrcB     = w_srcb;
  assign bus.PCSrc       = w_pcsrc;
  assign bus.IorD        = w_iord;
  assign bus.RegDst      = w_regdst;
  assign bus.MemtoReg    = w_memtoreg;
  assign bus.ALUSrcA     = w_srca;
  // Side-effecting strobes are held off while reset is asserted.
  assign bus.IRWrite     = w_irwrite  & rst_n;
  assign bus.MemWrite    = w_memwrite & rst_n;
  assign bus.RegWrite    = w_regwrite & rst_n;
  assign bus.PCEn        = (w_pcwrite | (w_branch & bus.zero_flag)) & rst_n;
  assign bus.instr_done  = w_done    & rst_n;
  assign bus.illegal_op  = w_illegal & rst_n;

endmodule

// File: tb/tb_mc_control.sv
// Randomized scoreboard bench for mc_control: an instruction-level model
// pushes one expected output record per cycle, a negedge monitor compares.
module tb_mc_control;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       iord, irw, memw, regdst, memtoreg, regw, srca, pcen, done, ill;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mc_control_if bus ();

  mc_control #(.MUL_EN(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  rec_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Model of the R-type funct table: {unmapped, alu op}.
  function automatic logic [3:0] fmap(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0100;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0110;
      6'b011000: return 4'b0101;
      default:   return 4'b1000;
    endcase
  endfunction

  function automatic bit op_known(input logic [5:0] o);
    return (o == 6'b100011) || (o == 6'b101011) || (o == 6'b000000) ||
           (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
  endfunction

  // Expected outputs for one cycle spent in step s of an instruction.
  function automatic rec_t exp_rec(input logic [3:0] s, input logic [5:0] o,
                                   input logic [5:0] f, input logic zf,
                                   input logic rn, input logic fbad);
    rec_t r;
    logic pcw, br;
    logic [3:0] fm;
    r = '0;
    r.st = s;
    r.alu = 3'b010;
    pcw = 1'b0;
    br = 1'b0;
    fm = fmap(f);
    case (s)
      4'd0:  begin r.irw = 1'b1; pcw = 1'b1; r.srcb = 2'b01; end
      4'd1:  begin r.srcb = 2'b11; r.ill = !op_known(o); end
      4'd2:  begin r.srca = 1'b1; r.srcb = 2'b10; end
      4'd3:  r.iord = 1'b1;
      4'd4:  begin r.memtoreg = 1'b1; r.regw = 1'b1; r.done = 1'b1; end
      4'd5:  begin r.iord = 1'b1; r.memw = 1'b1; r.done = 1'b1; end
      4'd6:  begin r.srca = 1'b1; r.alu = fm[2:0]; end
      4'd7:  begin r.regdst = 1'b1; r.regw = !fbad; r.ill = fbad; r.done = 1'b1; end
      4'd8:  begin r.srca = 1'b1; r.alu = 3'b100; r.pcsrc = 2'b01; br = 1'b1; r.done = 1'b1; end
      4'd9:  begin r.srca = 1'b1; r.srcb = 2'b10; end
      4'd10: begin r.regw = 1'b1; r.done = 1'b1; end
      4'd11: begin r.pcsrc = 2'b10; pcw = 1'b1; r.done = 1'b1; end
      default: r = '0;
    endcase
    r.pcen = pcw | (br & zf);
    if (!rn) begin
      r.irw = 1'b0; r.memw = 1'b0; r.regw = 1'b0;
      r.pcen = 1'b0; r.done = 1'b0; r.ill = 1'b0;
    end
    return r;
  endfunction

  // Drive one cycle of inputs, record its expectation, advance past the edge.
  task automatic step(input logic [3:0] s, input logic [5:0] o, input logic [5:0] f,
                      input logic rn, input logic fbad, input int zf_force);
    logic zf;
    zf = (zf_force < 0) ? 1'($urandom_range(0, 1)) : 1'(zf_force);
    bus.op = o;
    bus.funct = f;
    bus.zero_flag = zf;
    rst_n = rn;
    exp_q.push_back(exp_rec(s, o, f, zf, rn, fbad));
    @(posedge clk);
    #1;
  endtask

  // One instruction: state trace derived from the opcode; garbage op/funct
  // is driven in every step where they must be ignored.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input int zf_force, input int rst_step);
    logic [3:0] seq[$];
    logic [3:0] fm;
    logic [5:0] ov, fv;
    logic rn;
    bit   smp;
    fm = fmap(f);
    case (o)
      6'b100011: seq = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      6'b101011: seq = '{4'd0, 4'd1, 4'd2, 4'd5};
      6'b000000: seq = '{4'd0, 4'd1, 4'd6, 4'd7};
      6'b000100: seq = '{4'd0, 4'd1, 4'd8};
      6'b001000: seq = '{4'd0, 4'd1, 4'd9, 4'd10};
      6'b000010: seq = '{4'd0, 4'd1, 4'd11};
      default:   seq = '{4'd0, 4'd1};
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      smp = (seq[i] == 4'd1) || (seq[i] == 4'd2) || (seq[i] == 4'd6);
      ov = smp ? o : 6'($urandom);
      fv = smp ? f : 6'($urandom);
      rn = (i == rst_step) ? 1'b0 : 1'b1;
      step(seq[i], ov, fv, rn, fm[3], zf_force);
      if (!rn) break;
    end
  endtask

  // Monitor: compare each presented cycle against the oldest expectation.
  always @(negedge clk) begin
    rec_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.st = bus.state;         a.alu = bus.ALU_control;
      a.srcb = bus.ALUSrcB;     a.pcsrc = bus.PCSrc;
      a.iord = bus.IorD;        a.irw = bus.IRWrite;
      a.memw = bus.MemWrite;    a.regdst = bus.RegDst;
      a.memtoreg = bus.MemtoReg; a.regw = bus.RegWrite;
      a.srca = bus.ALUSrcA;     a.pcen = bus.PCEn;
      a.done = bus.instr_done;  a.ill = bus.illegal_op;
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL cycle_vec%0d exp_state=%0d got=%h exp=%h", n_vec, e.st, a, e);
      end
    end
  end

  logic [5:0] legal_ops[6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0] legal_fn[6]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011000};

  initial begin
    int k, wait_cnt;
    logic [5:0] o, f;
    bus.op = 6'b0;
    bus.funct = 6'b0;
    bus.zero_flag = 1'b0;
    @(posedge clk);
    #1;
    // Second reset cycle: state already FETCH, strobes masked.
    step(4'd0, 6'b100011, 6'b0, 1'b0, 1'b0, 1);

    run_instr(6'b100011, 6'b000000, -1, -1);   // lw
    run_instr(6'b000000, 6'b100010, -1, -1);   // sub
    run_instr(6'b000100, 6'b000000, 1, -1);    // beq taken
    run_instr(6'b000100, 6'b000000, 0, -1);    // beq not taken
    run_instr(6'b111111, 6'b000000, -1, -1);   // illegal op
    run_instr(6'b000000, 6'b000111, -1, -1);   // illegal funct
    run_instr(6'b000000, 6'b011000, -1, -1);   // mul
    run_instr(6'b101011, 6'b000000, -1, 3);    // sw, reset in MEMWR
    run_instr(6'b000010, 6'b000000, -1, -1);   // j
    run_instr(6'b001000, 6'b000000, -1, -1);   // addi
    run_instr(6'b100011, 6'b000000, -1, 2);    // lw, reset in MEMADR

    for (int n = 0; n < 120; n++) begin
      k = $urandom_range(0, 6);
      o = (k < 6) ? legal_ops[k] : 6'($urandom);
      k = $urandom_range(0, 7);
      f = (k < 6) ? legal_fn[k] : 6'($urandom);
      run_instr(o, f, -1, ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4) : -1);
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
